// File: rtl/demux_rr_sched.sv
// demux_rr_sched: 1-to-4 demux scheduler with a one-entry registered output stage.
// Destinations come from a round-robin burst scheduler that skips disabled
// channels (mode 0) or from a per-word fixed destination (mode 1).
module demux_rr_sched #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [3:0]       chan_en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_dest,
    output logic             in_ready,
    output logic [3:0]       out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic [3:0]       out_ready,
    output logic [1:0]       sel,
    output logic             err
);

    localparam int unsigned BW = 8;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t        state;
    logic [BW-1:0] bcnt;

    logic          drain;
    logic          any_target;
    logic          accept;
    logic [2:0]    skip;
    logic [2:0]    adv;
    logic [1:0]    rr_dest;
    logic [BW-1:0] rr_cnt;
    logic          burst_done;
    logic [1:0]    rr_sel_next;
    logic [BW-1:0] rr_bcnt_next;
    logic [1:0]    dest;
    logic          drop;
    logic          load;

    // First enabled channel strictly after base, circular; returns {found, index}.
    function automatic logic [2:0] next_enabled(input logic [3:0] en, input logic [1:0] base);
        logic [2:0] r;
        logic [1:0] idx;
        r = 3'b000;
        for (int k = 3; k >= 1; k--) begin
            idx = 2'(base + 2'(k));
            if (en[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    // Handshake, destination selection and round-robin next-state computation.
    always_comb begin
        drain        = (state == ST_FULL) && (|(out_valid & out_ready));
        any_target   = mode ? 1'b1 : (|chan_en);
        in_ready     = rst_n && ((state == ST_EMPTY) || drain) && any_target;
        accept       = in_valid && in_ready;

        skip         = next_enabled(chan_en, sel);
        rr_dest      = (chan_en[sel] || !skip[2]) ? sel : skip[1:0];
        rr_cnt       = chan_en[sel] ? BW'(bcnt + BW'(1)) : BW'(1);
        burst_done   = (rr_cnt == BW'(BURST));
        adv          = next_enabled(chan_en, rr_dest);
        rr_sel_next  = rr_dest;
        rr_bcnt_next = rr_cnt;
        if (burst_done) begin
            rr_bcnt_next = '0;
            if (adv[2]) rr_sel_next = adv[1:0];
        end

        dest = mode ? in_dest : rr_dest;
        drop = !chan_en[dest];
        load = accept && !drop;
    end

    // Buffer state, registered outputs and scheduler pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            out_valid <= '0;
            out_data  <= '0;
            sel       <= '0;
            bcnt      <= '0;
            err       <= 1'b0;
        end else begin
            err <= accept && drop;

            if (load) begin
                state     <= ST_FULL;
                out_valid <= 4'b0001 << dest;
                out_data  <= in_data;
            end else if (drain) begin
                state     <= ST_EMPTY;
                out_valid <= '0;
            end

            if (mode) begin
                bcnt <= '0;
            end else if (accept) begin
                sel  <= rr_sel_next;
                bcnt <= rr_bcnt_next;
            end
        end
    end

endmodule

// File: tb/tb_demux_rr_sched.sv
// Self-checking bench for demux_rr_sched: directed sequences, a vector table
// and randomized traffic compared against a behavioural model.
module tb_demux_rr_sched;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned BURST = 4;

    logic             clk;
    logic             rst_n;
    logic             mode;
    logic [3:0]       chan_en;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_dest;
    logic             in_ready;
    logic [3:0]       out_valid;
    logic [WIDTH-1:0] out_data;
    logic [3:0]       out_ready;
    logic [1:0]       sel;
    logic             err;

    demux_rr_sched #(.WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .chan_en  (chan_en),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_dest  (in_dest),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .sel      (sel),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit               m_full;
    int               m_ch;
    logic [WIDTH-1:0] m_data;
    int               m_sel;
    int               m_bcnt;
    bit               m_err;

    typedef struct {
        logic       valid;
        logic [1:0] dest;
        logic [7:0] data;
        logic [3:0] exp_valid;
        logic [7:0] exp_data;
        logic       exp_err;
        logic [1:0] exp_sel;
        logic       exp_ready;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [3:0] onehot(input int c);
        return 4'(1 << c);
    endfunction

    task automatic model_reset();
        m_full = 0; m_ch = 0; m_data = '0; m_sel = 0; m_bcnt = 0; m_err = 0;
    endtask

    function automatic bit model_drain();
        return m_full && out_ready[m_ch];
    endfunction

    function automatic bit model_ready();
        return rst_n && (!m_full || model_drain()) && (mode || (chan_en != 4'b0));
    endfunction

    task automatic compare_model();
        check("model_in_ready", in_ready, model_ready());
        check("model_out_valid", out_valid, m_full ? onehot(m_ch) : 4'b0);
        check("model_out_data", out_data, m_data);
        check("model_sel", sel, m_sel);
        check("model_err", err, m_err);
    endtask

    // Advance the model by one clock edge using the currently applied inputs.
    task automatic model_advance();
        bit acc, drn, loaded;
        int d, cnt;
        if (!rst_n) begin
            model_reset();
            return;
        end
        drn    = model_drain();
        acc    = in_valid && model_ready();
        loaded = 0;
        m_err  = 0;
        if (mode) m_bcnt = 0;
        if (acc) begin
            if (mode) begin
                d = int'(in_dest);
                if (chan_en[d]) loaded = 1;
                else m_err = 1;
            end else begin
                if (chan_en[m_sel]) begin
                    d = m_sel;
                    cnt = m_bcnt + 1;
                end else begin
                    d = m_sel;
                    for (int k = 1; k <= 3; k++)
                        if (chan_en[(m_sel + k) % 4]) begin d = (m_sel + k) % 4; break; end
                    cnt = 1;
                end
                loaded = 1;
                if (cnt == BURST) begin
                    m_bcnt = 0;
                    m_sel = d;
                    for (int k = 1; k <= 3; k++)
                        if (chan_en[(d + k) % 4]) begin m_sel = (d + k) % 4; break; end
                end else begin
                    m_bcnt = cnt;
                    m_sel = d;
                end
            end
        end
        if (loaded) begin
            m_full = 1; m_ch = d; m_data = in_data;
        end else if (drn) begin
            m_full = 0;
        end
    endtask

    task automatic tick_sample();
        @(negedge clk);
        compare_model();
    endtask

    task automatic tick_edge();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        tick_sample();
        tick_edge();
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b0; chan_en = 4'hF; in_valid = 1'b0;
        in_data = '0; in_dest = '0; out_ready = 4'hF;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        tick_sample();
        check("reset_out_valid", out_valid, 4'b0);
        check("reset_out_data", out_data, 8'h00);
        check("reset_sel", sel, 2'd0);
        check("reset_err", err, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);
        tick_edge();

        // Round-robin bursts of 4 across all channels, no bubbles
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            tick_sample();
            check("rr_ready", in_ready, 1'b1);
            if (i > 0) begin
                check("rr_valid", out_valid, onehot((i - 1) / 4));
                check("rr_data", out_data, 8'(i - 1));
            end
            tick_edge();
        end
        in_valid = 1'b0;
        tick_sample();
        check("rr_last_valid", out_valid, 4'b1000);
        check("rr_last_data", out_data, 8'h0F);
        check("rr_sel_wrap", sel, 2'd0);
        tick_edge();

        // Skip disabled channels
        chan_en = 4'b1010;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h20 + i);
            tick_sample();
            if (i > 0) check("skip_valid", out_valid, (i - 1) < 4 ? 4'b0010 : 4'b1000);
            tick_edge();
        end
        in_valid = 1'b0;
        tick_sample();
        check("skip_last_valid", out_valid, 4'b1000);
        tick_edge();
        chan_en = 4'b0000;
        tick_sample();
        check("no_target_ready", in_ready, 1'b0);
        tick_edge();

        // Backpressure on ch0
        mode = 1'b1; chan_en = 4'hF; in_dest = 2'd0; in_data = 8'hA5;
        out_ready = 4'b1110; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick_sample();
            check("bp_valid", out_valid, 4'b0001);
            check("bp_data", out_data, 8'hA5);
            check("bp_ready", in_ready, 1'b0);
            tick_edge();
        end
        out_ready = 4'hF; in_valid = 1'b1; in_data = 8'h5A; in_dest = 2'd1;
        tick_sample();
        check("bp_release_ready", in_ready, 1'b1);
        tick_edge();
        in_valid = 1'b0;
        tick_sample();
        check("bp_next_valid", out_valid, 4'b0010);
        check("bp_next_data", out_data, 8'h5A);
        tick_edge();

        // Fixed mode with a dropped word (table-driven)
        tbl[0] = '{1'b1, 2'd2, 8'h11, 4'b0000, 8'h00, 1'b0, 2'd1, 1'b1};
        tbl[1] = '{1'b1, 2'd3, 8'h22, 4'b0100, 8'h11, 1'b0, 2'd1, 1'b1};
        tbl[2] = '{1'b1, 2'd0, 8'h33, 4'b0000, 8'h00, 1'b1, 2'd1, 1'b1};
        tbl[3] = '{1'b0, 2'd0, 8'h00, 4'b0001, 8'h33, 1'b0, 2'd1, 1'b1};
        tbl[4] = '{1'b0, 2'd0, 8'h00, 4'b0000, 8'h00, 1'b0, 2'd1, 1'b1};
        mode = 1'b1; chan_en = 4'b0111; out_ready = 4'hF;
        for (int i = 0; i < 5; i++) begin
            in_valid = tbl[i].valid; in_dest = tbl[i].dest; in_data = tbl[i].data;
            tick_sample();
            check("tbl_valid", out_valid, tbl[i].exp_valid);
            if (tbl[i].exp_valid != 4'b0) check("tbl_data", out_data, tbl[i].exp_data);
            check("tbl_err", err, tbl[i].exp_err);
            check("tbl_sel", sel, tbl[i].exp_sel);
            check("tbl_ready", in_ready, tbl[i].exp_ready);
            tick_edge();
        end

        // Reset asserted mid-operation with a word held for ch2
        chan_en = 4'hF; in_dest = 2'd2; in_data = 8'hC3; out_ready = 4'b0000; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 4'b0);
        check("mid_rst_sel", sel, 2'd0);
        check("mid_rst_data", out_data, 8'h00);
        check("mid_rst_ready", in_ready, 1'b0);
        model_reset();
        cycle();
        cycle();
        rst_n = 1'b1; mode = 1'b0; out_ready = 4'hF;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h40 + i);
            tick_sample();
            if (i == 1) check("post_rst_ch0", out_valid, 4'b0001);
            tick_edge();
        end
        in_valid = 1'b0;
        tick_sample();
        check("post_rst_burst_adv", out_valid, 4'b0010);
        tick_edge();

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(31) == 0) mode = ~mode;
            if ($urandom_range(7) == 0) chan_en = 4'($urandom);
            in_valid  = ($urandom_range(3) != 0);
            in_data   = 8'($urandom);
            in_dest   = 2'($urandom);
            out_ready = 4'($urandom) | 4'($urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_rr_sched.md
# demux_rr_sched

Scheduling controller for the 1-to-4 demultiplexer datapath. It accepts a single input word stream over a valid/ready handshake and dispatches each word to one of four output channels. It holds each word in a one-entry registered output stage. Destinations come either from a round-robin burst scheduler that skips disabled channels, or from a per-word fixed destination. It sits between a single producer and four downstream consumers and owns the demux select.

## Interface
- WIDTH, 8, data word width in bits
- BURST, 4, words assigned to one channel before round-robin advances (1..255)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- mode  input  1  0 = round-robin burst, 1 = fixed destination from in_dest
- chan_en  input  4  per-channel enable mask
- in_valid  input  1  producer word valid
- in_data  input  WIDTH  producer word
- in_dest  input  2  destination channel, used only when mode=1
- in_ready  output  1  controller accepts word this cycle
- out_valid  output  4  one-hot (or zero) valid per channel
- out_data  output  WIDTH  registered word, qualified by out_valid
- out_ready  input  4  per-channel consumer ready
- sel  output  2  channel the next accepted word is assigned to (round-robin pointer)
- err  output  1  one-cycle pulse: fixed-mode word to a disabled channel was dropped

## Operation
- Buffer FSM:
  - EMPTY: out_valid=0.
  - FULL: one word held. out_valid has exactly one bit set, at the held word's channel ch.
- Drain: drain = FULL && out_ready[ch].
- in_ready = (EMPTY || drain) && any_target.
  - any_target = |chan_en in mode 0.
  - any_target = 1 in mode 1, because drops are always accepted.
- Accept: accept = in_valid && in_ready.
  - Word to an enabled destination: the buffer loads in_data and the one-hot of the destination. State is FULL.
  - Dropped word: the buffer keeps draining normally and err=1 next cycle.
- Transitions:
  - EMPTY→FULL on a non-dropped accept.
  - FULL→EMPTY on drain without a non-dropped accept.
  - FULL stays FULL on drain with a simultaneous non-dropped accept (back-to-back, new word/channel).
  - FULL stays FULL with no drain: out_data and out_valid are held stable.
- Round-robin (mode 0), per accepted word:
  - If chan_en[sel]=1: destination = sel and bcnt increments.
  - If chan_en[sel]=0: destination = first enabled channel searching sel+1, sel+2, … circularly (wrap 3→0). sel moves there and bcnt = 1.
  - When bcnt reaches BURST after an assignment, bcnt clears. sel advances to the next enabled channel after the destination, circularly. If no other channel is enabled, sel stays.
- Fixed (mode 1):
  - Destination = in_dest.
  - If chan_en[in_dest]=0: the word is accepted, dropped, and err pulses.
  - bcnt is held at 0 while mode=1. sel is unchanged.
- Changes to chan_en or mode take effect on the next accept. A word already buffered is delivered even if its channel is disabled afterwards.
- Reset (asynchronous assert, mid-operation included): FSM=EMPTY, out_valid=0, out_data=0, sel=0, bcnt=0, err=0. A buffered word is lost. in_ready=0 while rst_n=0.

## Timing
- Latency: in_data accepted at edge N appears on out_data/out_valid after edge N (first cycle visible = N+1).
- Throughput: 1 word/cycle with continuous out_ready on the targeted channels, including when the channel changes between words.
- in_ready is combinational from state, out_ready, chan_en and mode. It has no path from in_valid.
- out_valid and out_data are registered. Once asserted, out_valid/out_data must not change until drain (AXI-style stability).
- err is registered, high exactly one cycle per dropped word.
- sel and bcnt update on the accepting edge.

## Test plan
- Reset: release rst_n with chan_en=4'hF, mode=0 → out_valid=0, out_data=0, sel=0, err=0, in_ready=1.
- Round-robin burst: BURST=4, all out_ready=1, stream 16 words 0x00..0x0F → 0x00–03 on ch0, 0x04–07 ch1, 0x08–0B ch2, 0x0C–0F ch3. Each word appears 1 cycle after accept, no bubbles, sel wraps to 0.
- Skip disabled: chan_en=4'b1010, 8 words → words 0–3 on ch1, 4–7 on ch3, no out_valid on ch0/ch2. chan_en=0 → in_ready=0.
- Backpressure: hold out_ready[0]=0 for 5 cycles with a word 0xA5 buffered for ch0 → out_valid=4'b0001, out_data=0xA5 stable, in_ready=0. Raise out_ready[0] → drain and accept the next word the same cycle.
- Fixed mode / drop: mode=1, chan_en=4'b0111, in_dest sequence 2,3,0 with data 0x11,0x22,0x33 → 0x11 on ch2. 0x22 is accepted and dropped with err=1 for one cycle. 0x33 on ch0, sel unchanged.
- Reset mid-operation: word buffered for ch2 with out_ready=0, assert rst_n low between edges → out_valid=0 immediately, sel=0. After release, the next word goes to ch0 with bcnt restarted.
